// File: rtl/aer_sample_sequencer_if.sv
// Core-side AER input port: 4-phase event handshake, sample mode, completion and goodness.
// The sequencer uses the master modport; a core or core model uses the slave modport.
interface aer_sample_sequencer_if #(
   parameter int AER_WIDTH      = 12,
   parameter int GOODNESS_WIDTH = 32
);
   logic [AER_WIDTH-1:0]      CORE_AERIN_ADDR;
   logic                      CORE_AERIN_REQ;
   logic                      CORE_AERIN_ACK;
   logic                      CORE_IS_POS;
   logic                      CORE_IS_TRAIN;
   logic                      CORE_DONE;
   logic [GOODNESS_WIDTH-1:0] CORE_GOODNESS;

   modport master (
      output CORE_AERIN_ADDR, CORE_AERIN_REQ, CORE_IS_POS, CORE_IS_TRAIN,
      input  CORE_AERIN_ACK, CORE_DONE, CORE_GOODNESS
   );

   modport slave (
      input  CORE_AERIN_ADDR, CORE_AERIN_REQ, CORE_IS_POS, CORE_IS_TRAIN,
      output CORE_AERIN_ACK, CORE_DONE, CORE_GOODNESS
   );
endinterface

// File: rtl/aer_sample_sequencer.sv
// Replays host-preloaded AER events into the core over a 4-phase handshake and reports the sample goodness.
// Define SEQ_TIMEOUT_EN to add a watchdog that aborts a stuck handshake or a missing completion.
module aer_sample_sequencer #(
   parameter int AER_WIDTH      = 12,
   parameter int FIFO_DEPTH     = 64,
   parameter int GOODNESS_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EVT_WR_EN,
   input  logic [AER_WIDTH-1:0]      EVT_WR_ADDR,
   input  logic                      EVT_WR_LAST,
   output logic                      EVT_FULL,
   output logic                      EVT_OVF,
   input  logic                      START,
   input  logic                      START_POS,
   input  logic                      START_TRAIN,
   output logic                      BUSY,
   aer_sample_sequencer_if.master    core,
   output logic [GOODNESS_WIDTH-1:0] RESULT_GOODNESS,
   output logic                      RESULT_VALID,
   output logic                      TIMEOUT_ERR
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_RELEASE,
      ST_WAIT_DONE,
      ST_REPORT
   } state_e;

   // FIFO entry: {last, addr}
   typedef logic [AER_WIDTH:0] entry_t;

   state_e                    state_q;
   logic                      req_q;
   logic [AER_WIDTH-1:0]      addr_q;
   logic                      last_q;
   logic                      is_pos_q;
   logic                      is_train_q;
   logic                      busy_q;
   logic                      ovf_q;
   logic                      tmo_err_q;
   logic [GOODNESS_WIDTH-1:0] result_q;
   logic                      valid_q;

   entry_t                    mem_q [FIFO_DEPTH];
   logic [PW:0]               wr_ptr_q, wr_ptr_d;
   logic [PW:0]               rd_ptr_q, rd_ptr_d;
   logic                      full_q;
   logic                      empty;
   logic                      push;
   logic                      push_drop;
   logic                      pop;
   logic                      tmo_hit;
   entry_t                    rd_entry;

   // ---------------------------------------------------------------- FIFO
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign push      = EVT_WR_EN && !full_q;
   assign push_drop = EVT_WR_EN && full_q;
   assign pop       = (state_q == ST_LOAD) && !empty;
   assign rd_entry  = mem_q[rd_ptr_q[PW-1:0]];

   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      // A watchdog abort discards everything queued before this cycle's push.
      if (tmo_hit) begin
         rd_ptr_d = wr_ptr_q;
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= ((wr_ptr_d - rd_ptr_d) == FULL_COUNT);
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= {EVT_WR_LAST, EVT_WR_ADDR};
      end
   end

   // ------------------------------------------------------------ watchdog
`ifdef SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt_q;
   logic          tmo_run;
   logic          tmo_leave;

   assign tmo_run   = (state_q == ST_REQ) || (state_q == ST_RELEASE) ||
                      (state_q == ST_WAIT_DONE);
   assign tmo_leave = ((state_q == ST_REQ)       &&  core.CORE_AERIN_ACK) ||
                      ((state_q == ST_RELEASE)   && !core.CORE_AERIN_ACK) ||
                      ((state_q == ST_WAIT_DONE) &&  core.CORE_DONE);
   assign tmo_hit   = tmo_run && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (RST || !tmo_run || tmo_leave || tmo_hit) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         last_q     <= 1'b0;
         is_pos_q   <= 1'b0;
         is_train_q <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         tmo_err_q  <= 1'b0;
         result_q   <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (tmo_hit) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (START) begin
                     is_pos_q   <= START_POS;
                     is_train_q <= START_TRAIN;
                     ovf_q      <= 1'b0;
                     tmo_err_q  <= 1'b0;
                     busy_q     <= 1'b1;
                     state_q    <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (!empty) begin
                     addr_q  <= rd_entry[AER_WIDTH-1:0];
                     last_q  <= rd_entry[AER_WIDTH];
                     req_q   <= 1'b1;
                     state_q <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  if (core.CORE_AERIN_ACK) begin
                     req_q   <= 1'b0;
                     state_q <= ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (!core.CORE_AERIN_ACK) begin
                     state_q <= last_q ? ST_WAIT_DONE : ST_LOAD;
                  end
               end
               ST_WAIT_DONE: begin
                  if (core.CORE_DONE) begin
                     result_q <= core.CORE_GOODNESS;
                     valid_q  <= 1'b1;
                     state_q  <= ST_REPORT;
                  end
               end
               ST_REPORT: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
         // A dropped push outranks the clear issued by START in the same cycle.
         if (push_drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign EVT_FULL             = full_q;
   assign EVT_OVF              = ovf_q;
   assign BUSY                 = busy_q;
   assign core.CORE_AERIN_ADDR = addr_q;
   assign core.CORE_AERIN_REQ  = req_q;
   assign core.CORE_IS_POS     = is_pos_q;
   assign core.CORE_IS_TRAIN   = is_train_q;
   assign RESULT_GOODNESS      = result_q;
   assign RESULT_VALID         = valid_q;
   assign TIMEOUT_ERR          = tmo_err_q;

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// Directed bench for aer_sample_sequencer: behavioural core model on the AER port, hand-computed expectations.
// Define SEQ_TIMEOUT_EN on both files to exercise the watchdog instead of the indefinite-wait case.
module tb_aer_sample_sequencer;

   localparam int AW    = 12;
   localparam int DEPTH = 64;
   localparam int GW    = 32;
`ifdef SEQ_TIMEOUT_EN
   localparam int TMO   = 100;
`else
   localparam int TMO   = 65535;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EVT_WR_EN = 1'b0;
   logic [AW-1:0] EVT_WR_ADDR = '0;
   logic          EVT_WR_LAST = 1'b0;
   logic          EVT_FULL;
   logic          EVT_OVF;
   logic          START = 1'b0;
   logic          START_POS = 1'b0;
   logic          START_TRAIN = 1'b0;
   logic          BUSY;
   logic [GW-1:0] RESULT_GOODNESS;
   logic          RESULT_VALID;
   logic          TIMEOUT_ERR;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   aer_sample_sequencer_if #(.AER_WIDTH(AW), .GOODNESS_WIDTH(GW)) core_if ();

   aer_sample_sequencer #(
      .AER_WIDTH      (AW),
      .FIFO_DEPTH     (DEPTH),
      .GOODNESS_WIDTH (GW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .EVT_WR_EN       (EVT_WR_EN),
      .EVT_WR_ADDR     (EVT_WR_ADDR),
      .EVT_WR_LAST     (EVT_WR_LAST),
      .EVT_FULL        (EVT_FULL),
      .EVT_OVF         (EVT_OVF),
      .START           (START),
      .START_POS       (START_POS),
      .START_TRAIN     (START_TRAIN),
      .BUSY            (BUSY),
      .core            (core_if),
      .RESULT_GOODNESS (RESULT_GOODNESS),
      .RESULT_VALID    (RESULT_VALID),
      .TIMEOUT_ERR     (TIMEOUT_ERR)
   );

   // Core model: ACK on the ack_delay-th cycle REQ is seen high, drop ACK once REQ is low.
   int            ack_delay = 2;
   bit            ack_en    = 1'b1;
   int            wait_cnt;
   int            mode_err  = 0;
   logic          exp_pos   = 1'b0;
   logic          exp_train = 1'b0;
   logic [AW-1:0] got_q [$];

   always @(posedge CLK) begin
      if (RST) begin
         core_if.CORE_AERIN_ACK <= 1'b0;
         wait_cnt               <= 0;
      end else if (core_if.CORE_AERIN_REQ && !core_if.CORE_AERIN_ACK) begin
         if (!ack_en) begin
            wait_cnt <= 0;
         end else if (wait_cnt + 1 >= ack_delay) begin
            core_if.CORE_AERIN_ACK <= 1'b1;
            wait_cnt               <= 0;
            got_q.push_back(core_if.CORE_AERIN_ADDR);
            if (core_if.CORE_IS_POS !== exp_pos || core_if.CORE_IS_TRAIN !== exp_train)
               mode_err <= mode_err + 1;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else if (!core_if.CORE_AERIN_REQ) begin
         core_if.CORE_AERIN_ACK <= 1'b0;
      end
   end

   int valid_cnt = 0;
   always @(negedge CLK) begin
      if (RESULT_VALID) valid_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic to_drive();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic l);
      EVT_WR_EN   = 1'b1;
      EVT_WR_ADDR = a;
      EVT_WR_LAST = l;
      to_drive();
      EVT_WR_EN   = 1'b0;
      EVT_WR_LAST = 1'b0;
   endtask

   task automatic start(input logic p, input logic t);
      got_q.delete();
      START       = 1'b1;
      START_POS   = p;
      START_TRAIN = t;
      exp_pos     = p;
      exp_train   = t;
      to_drive();
      START       = 1'b0;
      START_POS   = 1'b0;
      START_TRAIN = 1'b0;
   endtask

   task automatic wait_events(input int n, input string tag);
      int cyc = 0;
      while (got_q.size() < n && cyc < 5000) begin
         to_drive();
         cyc++;
      end
      check({tag, "_count"}, got_q.size(), n);
   endtask

   task automatic check_events(input string tag, input int base, input int n);
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         check($sformatf("%s_ev%0d", tag, i), got_q[i], base + i);
      end
   endtask

   // Let the final handshake close, raise DONE 10 cycles later, then check the one-cycle report.
   task automatic finish_sample(input logic [GW-1:0] g, input string tag);
      int cyc = 0;
      int v0;
      while ((core_if.CORE_AERIN_ACK || core_if.CORE_AERIN_REQ) && cyc < 100) begin
         to_drive();
         cyc++;
      end
      repeat (10) to_drive();
      v0 = valid_cnt;
      core_if.CORE_GOODNESS = g;
      core_if.CORE_DONE     = 1'b1;
      to_drive();
      core_if.CORE_DONE     = 1'b0;
      @(negedge CLK);
      check({tag, "_valid"}, RESULT_VALID, 1);
      check({tag, "_goodness"}, RESULT_GOODNESS, g);
      @(negedge CLK);
      check({tag, "_valid_drop"}, RESULT_VALID, 0);
      check({tag, "_busy_end"}, BUSY, 0);
      check({tag, "_pulses"}, valid_cnt - v0, 1);
      check({tag, "_goodness_hold"}, RESULT_GOODNESS, g);
      to_drive();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int req_seen;
      int v0;

      core_if.CORE_DONE     = 1'b0;
      core_if.CORE_GOODNESS = '0;
      RST = 1'b1;
      repeat (3) to_drive();
      RST = 1'b0;

      // Reset state
      @(negedge CLK);
      check("rst_full", EVT_FULL, 0);
      check("rst_ovf", EVT_OVF, 0);
      check("rst_busy", BUSY, 0);
      check("rst_req", core_if.CORE_AERIN_REQ, 0);
      check("rst_addr", core_if.CORE_AERIN_ADDR, 0);
      check("rst_pos", core_if.CORE_IS_POS, 0);
      check("rst_train", core_if.CORE_IS_TRAIN, 0);
      check("rst_valid", RESULT_VALID, 0);
      check("rst_goodness", RESULT_GOODNESS, 0);
      check("rst_tmo", TIMEOUT_ERR, 0);

      // Basic sample: 5, 17, 783(last), POS=TRAIN=1, GOODNESS 0x1234
      to_drive();
      push(12'd5, 1'b0);
      push(12'd17, 1'b0);
      push(12'd783, 1'b1);
      start(1'b1, 1'b1);
      @(negedge CLK);
      check("basic_busy_t1", BUSY, 1);
      check("basic_req_t1", core_if.CORE_AERIN_REQ, 0);
      @(negedge CLK);
      check("basic_req_t2", core_if.CORE_AERIN_REQ, 1);
      check("basic_addr_t2", core_if.CORE_AERIN_ADDR, 5);
      check("basic_mode", {core_if.CORE_IS_POS, core_if.CORE_IS_TRAIN}, 2'b11);
      wait_events(3, "basic");
      check("basic_ev0", got_q[0], 5);
      check("basic_ev1", got_q[1], 17);
      check("basic_ev2", got_q[2], 783);
      finish_sample(32'h0000_1234, "basic");
      check("basic_mode_err", mode_err, 0);
      check("basic_mode_keep", {core_if.CORE_IS_POS, core_if.CORE_IS_TRAIN}, 2'b11);

      // Overflow: 64 accepted, the 65th dropped
      for (int i = 0; i < 64; i++) push(AW'(100 + i), i == 63);
      @(negedge CLK);
      check("ovf_full_64", EVT_FULL, 1);
      check("ovf_ovf_64", EVT_OVF, 0);
      to_drive();
      push(12'd164, 1'b1);
      @(negedge CLK);
      check("ovf_ovf_65", EVT_OVF, 1);
      check("ovf_full_65", EVT_FULL, 1);
      to_drive();
      start(1'b0, 1'b1);
      @(negedge CLK);
      check("ovf_clear_on_start", EVT_OVF, 0);
      wait_events(64, "ovf");
      check_events("ovf", 100, 64);
      finish_sample(32'hCAFE_0001, "ovf");
      check("ovf_not_full", EVT_FULL, 0);

      // Empty-FIFO stall, then addr 9 pushed 20 cycles later
      start(1'b1, 1'b0);
      req_seen = 0;
      repeat (20) begin
         @(negedge CLK);
         if (core_if.CORE_AERIN_REQ) req_seen++;
      end
      check("stall_req_low", req_seen, 0);
      check("stall_busy", BUSY, 1);
      to_drive();
      push(12'd9, 1'b1);
      wait_events(1, "stall");
      check("stall_ev0", got_q[0], 9);
      finish_sample(32'hDEAD_BEEF, "stall");

      // Wrap and carry-over: write pointer sits at 4, second batch crosses 63 -> 0
      for (int i = 0; i < 40; i++) push(AW'(200 + i), i == 39);
      start(1'b0, 1'b0);
      wait_events(40, "wrap1");
      check_events("wrap1", 200, 40);
      finish_sample(32'h0000_0011, "wrap1");
      for (int i = 0; i < 40; i++) push(AW'(300 + i), i == 39);
      push(12'd900, 1'b0);
      push(12'd901, 1'b1);
      start(1'b1, 1'b1);
      wait_events(40, "wrap2");
      check_events("wrap2", 300, 40);
      finish_sample(32'h0000_0022, "wrap2");
      start(1'b0, 1'b0);
      wait_events(2, "carry");
      check_events("carry", 900, 2);
      finish_sample(32'h0000_0033, "carry");

      // Core never acknowledges
      ack_en = 1'b0;
      push(12'd42, 1'b1);
      start(1'b0, 1'b1);
      v0  = valid_cnt;
      cyc = 0;
      while (!core_if.CORE_AERIN_REQ && cyc < 10) begin
         @(negedge CLK);
         cyc++;
      end
`ifdef SEQ_TIMEOUT_EN
      repeat (99) @(negedge CLK);
      check("tmo_req_at_100", core_if.CORE_AERIN_REQ, 1);
      check("tmo_err_before", TIMEOUT_ERR, 0);
      @(negedge CLK);
      check("tmo_req_drop", core_if.CORE_AERIN_REQ, 0);
      check("tmo_err_set", TIMEOUT_ERR, 1);
      check("tmo_busy", BUSY, 0);
      check("tmo_no_valid", valid_cnt - v0, 0);
`else
      repeat (1000) @(negedge CLK);
      check("noack_req_held", core_if.CORE_AERIN_REQ, 1);
      check("noack_addr", core_if.CORE_AERIN_ADDR, 42);
      check("noack_tmo_zero", TIMEOUT_ERR, 0);
      check("noack_no_valid", valid_cnt - v0, 0);
`endif
      to_drive();
      RST = 1'b1;
      to_drive();
      RST = 1'b0;
      ack_en = 1'b1;

      // Reset asserted during RELEASE of the first of two events
      push(12'd50, 1'b0);
      push(12'd51, 1'b1);
      start(1'b1, 1'b1);
      cyc = 0;
      while (!core_if.CORE_AERIN_REQ && cyc < 100) begin
         @(negedge CLK);
         cyc++;
      end
      while (core_if.CORE_AERIN_REQ && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      check("mid_first_acked", got_q.size(), 1);
      RST = 1'b1;
      @(negedge CLK);
      check("mid_req", core_if.CORE_AERIN_REQ, 0);
      check("mid_busy", BUSY, 0);
      check("mid_mode", {core_if.CORE_IS_POS, core_if.CORE_IS_TRAIN}, 2'b00);
      check("mid_addr", core_if.CORE_AERIN_ADDR, 0);
      check("mid_goodness", RESULT_GOODNESS, 0);
      check("mid_valid", RESULT_VALID, 0);
      check("mid_full", EVT_FULL, 0);
      RST = 1'b0;
      to_drive();
      start(1'b0, 1'b0);
      req_seen = 0;
      repeat (10) begin
         @(negedge CLK);
         if (core_if.CORE_AERIN_REQ) req_seen++;
      end
      check("mid_flushed", req_seen, 0);
      to_drive();
      push(12'd77, 1'b1);
      wait_events(1, "mid");
      check("mid_ev0", got_q[0], 77);
      finish_sample(32'h0000_7777, "mid");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
